// File: rtl/skew_buffer3.sv
// rtl/skew_buffer3.sv - ping-pong input skew buffer, lane j delayed by j drain steps
// Optional bank clearing on release/reset: define SKEW_BUF_CLEAR_EN.
module skew_buffer3 #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int DEPTH      = 4,
    localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     write,
    input  logic [PW-1:0]                            row_ptr,
    input  logic signed [LANES-1:0][DATA_WIDTH-1:0]  data_in,
    input  logic                                     commit,
    output logic                                     wr_ready,
    input  logic                                     enable,
    output logic signed [LANES-1:0][DATA_WIDTH-1:0]  data_out,
    output logic [LANES-1:0]                         lane_valid,
    output logic                                     busy,
    output logic                                     done
);

    localparam int T  = DEPTH + LANES - 1;
    localparam int CW = $clog2(DEPTH + LANES);

    typedef enum logic {IDLE, DRAIN} state_t;

    logic [DATA_WIDTH-1:0] mem [2][DEPTH][LANES];

    state_t                                  state, state_nx;
    logic [CW-1:0]                           cnt, cnt_nx;
    logic [1:0]                              full, full_nx;
    logic                                    fill_sel, drain_sel;
    logic                                    wr_en, commit_en, step, last;
    logic signed [LANES-1:0][DATA_WIDTH-1:0] step_data;
    logic [LANES-1:0]                        step_valid;

    assign wr_ready  = !full[fill_sel];
    assign wr_en     = write && wr_ready && (int'(row_ptr) < DEPTH);
    assign commit_en = commit && wr_ready;
    assign step      = (state == DRAIN) && enable;
    assign last      = step && (cnt == CW'(T - 1));
    assign busy      = (state == DRAIN);

    // Release and commit always address different banks, so both apply.
    always_comb begin
        full_nx = full;
        if (last)
            full_nx[drain_sel] = 1'b0;
        if (commit_en)
            full_nx[fill_sel] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (full[drain_sel]) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end
            end
            DRAIN: begin
                if (last) begin
                    cnt_nx = '0;
                    if (!full[!drain_sel])
                        state_nx = IDLE;
                end else if (step) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Diagonal read: lane j shows row cnt-j of the draining bank.
    always_comb begin
        step_data  = '0;
        step_valid = '0;
        for (int j = 0; j < LANES; j++) begin
            int idx;
            idx = int'(cnt) - j;
            if (idx >= 0 && idx < DEPTH) begin
                step_data[j]  = mem[drain_sel][PW'(idx)][j];
                step_valid[j] = 1'b1;
            end
        end
    end

`ifdef SKEW_BUF_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < DEPTH; r++)
                    for (int j = 0; j < LANES; j++)
                        mem[b][r][j] <= '0;
        end else begin
            if (last)
                for (int r = 0; r < DEPTH; r++)
                    for (int j = 0; j < LANES; j++)
                        mem[drain_sel][r][j] <= '0;
            if (wr_en)
                for (int j = 0; j < LANES; j++)
                    mem[fill_sel][row_ptr][j] <= data_in[j];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            for (int j = 0; j < LANES; j++)
                mem[fill_sel][row_ptr][j] <= data_in[j];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            full       <= '0;
            fill_sel   <= 1'b0;
            drain_sel  <= 1'b0;
            data_out   <= '0;
            lane_valid <= '0;
            done       <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            full  <= full_nx;
            if (commit_en)
                fill_sel <= !fill_sel;
            if (last)
                drain_sel <= !drain_sel;
            if (step) begin
                data_out   <= step_data;
                lane_valid <= step_valid;
                done       <= last;
            end else if (state == DRAIN) begin
                lane_valid <= '0;
                done       <= 1'b0;
            end else begin
                data_out   <= '0;
                lane_valid <= '0;
                done       <= 1'b0;
            end
        end
    end

endmodule
